// File: rtl/alu_seq_ctrl.sv
// Vector sequencer: reads each element from RAM, runs it through an external ALU, writes the result back in place.
// Build macro SEQ_PERF_CNT_EN adds a saturating busy-cycle counter on output perf_cycles.
module alu_seq_ctrl #(
  parameter int ADDR_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SEQ_PERF_CNT_EN
  output logic [15:0] perf_cycles,
`endif
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [7:0]  length,
  input  logic [3:0]  aluop,
  input  logic [31:0] operand,
  output logic        busy,
  output logic        done,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result
);

  localparam logic [31:0] L_STEP = 32'(ADDR_STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_EX,
    S_WR,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic        r_ram_we;
  logic [31:0] r_ram_addr;
  logic [31:0] r_addr;
  logic [7:0]  r_cnt;
  logic [7:0]  r_len;
  logic [3:0]  r_op;
  logic [31:0] r_operand;
  logic [31:0] r_result;
  logic        w_in_ex;
  logic        w_accept;

  assign w_in_ex  = (r_state == S_EX);
  assign w_accept = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_op       <= '0;
      r_operand  <= '0;
      r_result   <= '0;
    end else begin
      r_done   <= 1'b0;
      r_ram_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr    <= base_addr;
            r_len     <= length;
            r_op      <= aluop;
            r_operand <= operand;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            if (length != 8'd0) begin
              r_ram_addr <= base_addr;
              r_state    <= S_RD;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_RD: begin
          r_state <= S_EX;
        end
        S_EX: begin
          // ram_rdata is valid now, so the ALU result reflects the element just read
          r_result <= alu_result;
          r_ram_we <= 1'b1;
          r_state  <= S_WR;
        end
        S_WR: begin
          if (r_cnt == r_len - 8'd1) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt      <= r_cnt + 8'd1;
            r_addr     <= r_addr + L_STEP;
            r_ram_addr <= r_addr + L_STEP;
            r_state    <= S_RD;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] r_perf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf <= '0;
    end else if (w_accept) begin
      r_perf <= '0;
    end else if (r_busy && (r_perf != 16'hFFFF)) begin
      r_perf <= r_perf + 16'd1;
    end
  end

  assign perf_cycles = r_perf;
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_we ? r_result : '0;
  assign alu_op    = w_in_ex ? r_op : '0;
  assign alu_a     = w_in_ex ? ram_rdata : '0;
  assign alu_b     = w_in_ex ? r_operand : '0;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: RAM and ALU models, directed cases plus randomized vector runs.
module tb_alu_seq_ctrl;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [7:0]  length = '0;
  logic [3:0]  aluop = '0;
  logic [31:0] operand = '0;
  logic        busy, done, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0] perf_cycles;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int done_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  // 256-word RAM decoded on addr[9:2]; pokes come in through the same port process
  logic [31:0] mem [0:255];
  logic        poke_en = 1'b0;
  logic [31:0] poke_addr = '0;
  logic [31:0] poke_data = '0;

  alu_seq_ctrl #(.ADDR_STEP(STEP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SEQ_PERF_CNT_EN
    .perf_cycles(perf_cycles),
`endif
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .aluop      (aluop),
    .operand    (operand),
    .busy       (busy),
    .done       (done),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      default: return ~a;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b);

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem[a[9:2]];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;
    else if (poke_en) mem[poke_addr[9:2]] <= poke_data;
    ram_rdata <= mem[ram_addr[9:2]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: records writes/done, and checks the idle-value rules every cycle
  always @(negedge clk) begin
    if (ram_we) begin
      wr_addr_q.push_back(ram_addr);
      wr_data_q.push_back(ram_wdata);
      chk("alu_zero_in_wr", {32'h0, alu_a | alu_b | {28'h0, alu_op}}, 64'h0);
    end else begin
      chk("wdata_zero_no_we", {32'h0, ram_wdata}, 64'h0);
    end
    if (!busy) chk("alu_zero_idle", {32'h0, alu_a | alu_b | {28'h0, alu_op}}, 64'h0);
    if (done) done_q.push_back(cyc);
    if (busy) busy_cnt++;
  end

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1;
    poke_addr = a;
    poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] base, input int len,
                        input logic [3:0] op, input logic [31:0] opnd, input bit glitch);
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    logic [31:0] a;
    logic [31:0] keep;
    int t0;
    @(negedge clk);
    for (int i = 0; i < len; i++) begin
      a = base + 32'(i * STEP);
      ea.push_back(a);
      ed.push_back(alu_fn(op, rd_mem(a), opnd));
    end
    keep = rd_mem(base);
    wr_addr_q.delete();
    wr_data_q.delete();
    done_q.delete();
    busy_cnt = 0;
    base_addr = base;
    length = 8'(len);
    aluop = op;
    operand = opnd;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    base_addr = $urandom;
    length = 8'($urandom);
    aluop = 4'($urandom);
    operand = $urandom;
    if (glitch) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    while (cyc < t0 + 3 * len + 4) @(negedge clk);
    chk({tag, ":done_count"}, done_q.size(), 1);
    if (done_q.size() > 0) chk({tag, ":done_latency"}, done_q[0] - t0, 1 + 3 * len);
    chk({tag, ":busy_cycles"}, busy_cnt, 1 + 3 * len);
    chk({tag, ":write_count"}, wr_addr_q.size(), len);
    for (int i = 0; i < len && i < wr_addr_q.size(); i++) begin
      chk({tag, ":wr_addr"}, wr_addr_q[i], ea[i]);
      chk({tag, ":wr_data"}, wr_data_q[i], ed[i]);
      chk({tag, ":ram_word"}, rd_mem(ea[i]), ed[i]);
    end
    if (len == 0) chk({tag, ":ram_untouched"}, rd_mem(base), keep);
    else chk({tag, ":addr_held"}, ram_addr, ea[len - 1]);
`ifdef SEQ_PERF_CNT_EN
    chk({tag, ":perf_cycles"}, perf_cycles, 1 + 3 * len);
`endif
    $display("txn %s base=%h len=%0d op=%0d operand=%h done_at=+%0d writes=%0d",
             tag, base, len, op, opnd, (done_q.size() > 0) ? done_q[0] - t0 : -1, wr_addr_q.size());
  endtask

  initial begin
    int nwe;
    logic [31:0] rb;
    int rl;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
`ifdef SEQ_PERF_CNT_EN
    chk("rst_perf", perf_cycles, 0);
`endif
    rst_n = 1'b1;

    poke(32'h10, 32'd5);
    run_op("single_add", 32'h10, 1, 4'd0, 32'd3, 1'b0);
    chk("single_add:result8", rd_mem(32'h10), 32'd8);

    poke(32'h20, 32'd1);
    poke(32'h24, 32'd2);
    poke(32'h28, 32'd3);
    run_op("three_add", 32'h20, 3, 4'd0, 32'd10, 1'b0);
    chk("three_add:w2", rd_mem(32'h28), 32'd13);

    poke(32'h40, 32'hDEAD_BEEF);
    run_op("zero_len", 32'h40, 0, 4'd0, 32'd1, 1'b0);

    poke(32'hFFFF_FFFC, 32'd100);
    poke(32'h0, 32'd200);
    run_op("addr_wrap", 32'hFFFF_FFFC, 2, 4'd1, 32'd7, 1'b0);

    poke(32'h80, 32'h0F0F);
    poke(32'h84, 32'h00FF);
    run_op("start_in_rd", 32'h80, 2, 4'd4, 32'hFFFF, 1'b1);

    // Reset asserted mid-cycle during the write of the second of three elements
    poke(32'h100, 32'd7);
    poke(32'h104, 32'd8);
    poke(32'h108, 32'd9);
    @(negedge clk);
    done_q.delete();
    base_addr = 32'h100;
    length = 8'd3;
    aluop = 4'd1;
    operand = 32'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nwe = 0;
    for (int k = 0; k < 30 && nwe < 2; k++) begin
      if (ram_we) nwe++;
      if (nwe < 2) @(negedge clk);
    end
    chk("midrst:reached_wr1", nwe, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst:busy", busy, 0);
    chk("midrst:ram_we", ram_we, 0);
    chk("midrst:ram_addr", ram_addr, 0);
    chk("midrst:ram_wdata", ram_wdata, 0);
    chk("midrst:alu", {32'h0, alu_a | alu_b | {28'h0, alu_op}}, 0);
    chk("midrst:done", done, 0);
`ifdef SEQ_PERF_CNT_EN
    chk("midrst:perf", perf_cycles, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst:no_done", done_q.size(), 0);
    chk("midrst:w0_written", rd_mem(32'h100), 32'd5);
    chk("midrst:w1_abandoned", rd_mem(32'h104), 32'd8);
    chk("midrst:w2_untouched", rd_mem(32'h108), 32'd9);
    $display("txn midrst base=00000100 len=3 reset during second write");
    run_op("after_rst", 32'h104, 2, 4'd0, 32'd1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      rb = $urandom & 32'hFFFF_FFFC;
      rl = $urandom_range(0, 10);
      for (int i = 0; i < rl; i++) poke(rb + 32'(i * STEP), $urandom);
      if (rl == 0) poke(rb, $urandom);
      run_op($sformatf("rand%0d", r), rb, rl, 4'($urandom_range(0, 7)), $urandom, r[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter ADDR_STEP, default 4: address increment between consecutive elements.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a vector operation; sampled only in IDLE.
REQ-005 base_addr  input  32  RAM address of the first element.
REQ-006 length  input  8  element count N (0..255).
REQ-007 aluop  input  4  ALU operation code applied to every element.
REQ-008 operand  input  32  second ALU operand (data_in2), constant for the whole operation.
REQ-009 busy  output  1  high from the cycle after start is accepted until the DONE cycle, inclusive.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 ram_we  output  1  RAM write_enable.
REQ-012 ram_addr  output  32  RAM addr.
REQ-013 ram_wdata  output  32  RAM data_in.
REQ-014 ram_rdata  input  32  RAM data_out; valid the cycle after ram_addr is presented with ram_we=0.
REQ-015 alu_op  output  4  ALU aluop.
REQ-016 alu_a  output  32  ALU data_in1.
REQ-017 alu_b  output  32  ALU data_in2.
REQ-018 alu_result  input  32  ALU data_out, combinational from alu_op/alu_a/alu_b.

Function
REQ-019 States: IDLE, RD, EX, WR, DONE; all outputs registered or decoded from registered state.
REQ-020 IDLE with start=1: latch base_addr, length, aluop, operand; clear element counter; go to RD if length!=0, else DONE.
REQ-021 RD: ram_addr=current address, ram_we=0; next state EX.
REQ-022 EX: alu_a=ram_rdata, alu_b=latched operand, alu_op=latched aluop; capture alu_result into result register; next state WR.
REQ-023 WR: ram_we=1, ram_addr=current address, ram_wdata=result register; if counter==N-1 go to DONE, else increment counter, address+=ADDR_STEP, go to RD.
REQ-024 DONE: done=1, busy=1 for exactly one cycle; next state IDLE.
REQ-025 Address arithmetic is modulo 2^32; wrap past 0xFFFFFFFF is silent.
REQ-026 Latency: start accepted in cycle T; done asserted in cycle T+1+3N (N=0 gives T+1).
REQ-027 start while not in IDLE is ignored; input changes after acceptance have no effect.
REQ-028 ram_we is high only in WR; outside WR, ram_addr holds last value, ram_wdata=0.
REQ-029 alu_op/alu_a/alu_b are 0 outside EX.

Reset
REQ-030 rst_n low forces IDLE immediately, regardless of clk, including mid-operation.
REQ-031 Reset values: busy=0, done=0, ram_we=0, ram_addr=0, ram_wdata=0, alu_op=0, alu_a=0, alu_b=0, counter, latches and result register=0.
REQ-032 A write in progress when reset asserts is abandoned; ram_we drops asynchronously.

Configuration
REQ-033 Macro SEQ_PERF_CNT_EN defined: adds output perf_cycles (16 bits), cleared on start acceptance, incremented each busy cycle, saturating at 0xFFFF, held after done, reset to 0.
REQ-034 SEQ_PERF_CNT_EN undefined: perf_cycles port and counter logic absent; all other behaviour identical.

Verification
REQ-035 RAM[0x10]=5, base_addr=0x10, length=1, aluop=ADD, operand=3 -> RAM[0x10]=8, done exactly 4 cycles after start.
REQ-036 RAM[0x20,0x24,0x28]=1,2,3, length=3, ADD operand=10 -> 11,12,13; done at T+10; perf_cycles=10 with SEQ_PERF_CNT_EN.
REQ-037 length=0, start=1 -> done at T+1, ram_we never asserted, RAM unchanged.
REQ-038 base_addr=0xFFFFFFFC, length=2, ADDR_STEP=4 -> writes to 0xFFFFFFFC then 0x00000000.
REQ-039 start pulsed during RD of a 2-element run -> ignored; single done; only 2 writes observed.
REQ-040 rst_n low during WR of element 1 of 3 -> all outputs at reset values immediately; subsequent start runs cleanly from IDLE.
